// File: rtl/ram_pkg.sv
// Shared geometry of the output feature-map memory (RAM_FMO).
// FMO_N_ELEM is deliberately not a power of two so address wrap is exercised.
package ram_pkg;
   localparam int FMO_N_ELEM = 12;
   localparam int PX_W       = 8;
   localparam int ADDR_W     = $clog2(FMO_N_ELEM);
endpackage

// File: rtl/fmo_arbiter_if.sv
// Bus bundle between PE writeback, DMA readout, RAM_FMO and the fmo_arbiter.
// slave = arbiter side, master = surrounding system (writeback, DMA, RAM).
interface fmo_arbiter_if;
   import ram_pkg::*;

   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [PX_W-1:0]   wr_data;
   logic              wr_ack;
   logic              rd_start;
   logic [ADDR_W-1:0] rd_base;
   logic [ADDR_W:0]   rd_len;
   logic              rd_busy;
   logic              rd_valid;
   logic [PX_W-1:0]   rd_data;
   logic              rd_done;
   logic [ADDR_W-1:0] ram_addr;
   logic [PX_W-1:0]   ram_data;
   logic              ram_write;
   logic [PX_W-1:0]   ram_res;
   logic [1:0]        dbg_state;

   // Handshakes: wr_req is held with stable addr/data until the cycle wr_ack=1,
   // which is the same cycle the write is presented to the RAM. rd_start is a
   // single-cycle pulse honoured only while rd_busy=0; rd_data is meaningful
   // only when rd_valid=1 and there is no back-pressure on the read stream.
   modport slave (
      input  wr_req, wr_addr, wr_data, rd_start, rd_base, rd_len, ram_res,
      output wr_ack, rd_busy, rd_valid, rd_data, rd_done,
             ram_addr, ram_data, ram_write, dbg_state
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_start, rd_base, rd_len, ram_res,
      input  wr_ack, rd_busy, rd_valid, rd_data, rd_done,
             ram_addr, ram_data, ram_write, dbg_state
   );
endinterface

// File: rtl/fmo_arbiter.sv
// Shares the single RAM_FMO port between writeback writes and DMA read bursts.
// Bursts walk consecutive addresses modulo FMO_N_ELEM; contention is round-robin.
module fmo_arbiter
   import ram_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   fmo_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   cnt_q;
   logic              last_wr_q;
   logic              issued_q;

   logic              reading;
   logic              grant_wr;
   logic              grant_rd;
   logic [ADDR_W-1:0] addr_next;

   // Arbitration only matters in READ; elsewhere a pending write always wins.
   always_comb begin
      reading   = (state_q == S_READ);
      grant_wr  = bus.wr_req && (!reading || !last_wr_q);
      grant_rd  = reading && !grant_wr;
      addr_next = (addr_q == ADDR_W'(FMO_N_ELEM - 1)) ? '0 : addr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.rd_start) state_d = (bus.rd_len == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            if (grant_rd && cnt_q == (ADDR_W+1)'(1)) state_d = S_FLUSH;
         end
         S_FLUSH: state_d = S_IDLE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.wr_ack    = grant_wr;
      bus.ram_write = grant_wr;
      bus.ram_addr  = '0;
      bus.ram_data  = '0;
      if (grant_wr) begin
         bus.ram_addr = bus.wr_addr;
         bus.ram_data = bus.wr_data;
      end else if (grant_rd) begin
         bus.ram_addr = addr_q;
      end
      bus.rd_busy   = (state_q != S_IDLE);
      bus.rd_done   = (state_q == S_FLUSH) || (state_q == S_DONE);
      bus.rd_valid  = issued_q;
      bus.rd_data   = bus.ram_res;
      bus.dbg_state = state_q;
   end

   // last_wr_q only tracks grants made while arbitration is live (READ).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         cnt_q     <= '0;
         last_wr_q <= 1'b0;
         issued_q  <= 1'b0;
      end else begin
         issued_q <= grant_rd;
         if (reading) last_wr_q <= grant_wr;
         if (state_q == S_IDLE && bus.rd_start) begin
            addr_q <= bus.rd_base;
            cnt_q  <= bus.rd_len;
         end else if (grant_rd) begin
            addr_q <= addr_next;
            cnt_q  <= cnt_q - 1'b1;
         end
      end
   end

endmodule

// File: doc/fmo_arbiter.md
# fmo_arbiter

Arbiter and readout sequencer for the single-port output feature-map memory (RAM_FMO). It shares the memory's one address/data port between the compute writeback path and the DMA readout path. Writebacks are single-word request/acknowledge transactions. Readouts are burst requests that the block expands into a stream of consecutive read addresses. It sits between the PE-array writeback logic, the DMA, and the RAM_FMO instance.

## Interface
Parameters (from ram_pkg):
- FMO_N_ELEM, package value, number of words in the FMO memory
- PX_W, package value, pixel/word width
- ADDR_W, $clog2(FMO_N_ELEM), memory address width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- wr_req  in  1  writeback request; held until wr_ack
- wr_addr  in  ADDR_W  writeback address
- wr_data  in  PX_W  writeback word
- wr_ack  out  1  writeback granted this cycle (combinational)
- rd_start  in  1  one-cycle burst start pulse
- rd_base  in  ADDR_W  first read address
- rd_len  in  ADDR_W+1  burst length, 0..FMO_N_ELEM
- rd_busy  out  1  burst in progress
- rd_valid  out  1  rd_data is valid
- rd_data  out  PX_W  read word (ram_res passthrough)
- rd_done  out  1  one-cycle pulse at end of burst
- ram_addr  out  ADDR_W  to RAM_FMO addr
- ram_data  out  PX_W  to RAM_FMO data
- ram_write  out  1  to RAM_FMO write
- ram_res  in  PX_W  from RAM_FMO res; 1-cycle registered latency

## Operation
- FSM states:
  - IDLE: rd_start with rd_len>0 latches the base and length, goes to READ.
  - rd_start with rd_len=0 goes to DONE; no RAM reads.
  - READ: issues one read per granted cycle. After the last issue, goes to FLUSH.
  - FLUSH: waits one cycle for the last word, pulses rd_done, returns to IDLE.
  - DONE (zero-length only): pulses rd_done for one cycle, returns to IDLE.
- rd_start outside IDLE is ignored. Latched burst parameters are unaffected.
- Each cycle exactly one of these is driven to the RAM: write, read, or nothing.
  - Write: ram_write=1, ram_addr=wr_addr, ram_data=wr_data, wr_ack=1.
  - Read: ram_write=0, ram_addr=current read address.
  - Nothing: ram_write=0, ram_addr=0, ram_data=0.
- Arbitration applies only when wr_req=1 and the FSM is in READ with issues remaining.
  - Round-robin: the requester not granted last wins.
  - The last_grant register resets to "read", so the write wins the first contention.
  - Outside READ, wr_req is granted every cycle.
- Read address sequence: rd_base, then next = (addr == FMO_N_ELEM-1) ? 0 : addr+1. Bursts wrap modulo FMO_N_ELEM, including non-power-of-2 sizes.
- Read counter: remaining count, ADDR_W+1 bits, decremented per issued read.
- rd_valid is the issued-read flag delayed one cycle. rd_data = ram_res, continuously.
- A write to an address that is also in the burst takes effect in grant order. The burst returns the old value if the read was issued first, the new value otherwise.

## Timing
- Reset values: rd_busy=0, rd_valid=0, rd_done=0, wr_ack=0, ram_write=0, ram_addr=0, ram_data=0. FSM=IDLE, last_grant=read, counters=0.
- Reset mid-burst: all state is cleared immediately. In-flight reads are discarded (rd_valid=0). No rd_done is generated.
- Burst of length N, rd_start at cycle T, no write contention:
  - rd_busy high from T+1 through T+N+1.
  - Read issues at T+1..T+N.
  - rd_valid at T+2..T+N+1.
  - rd_done at T+N+1, coincident with the last rd_valid.
- Each write granted during READ delays all subsequent read issues and rd_valid beats by one cycle.
- Zero-length burst: rd_busy high only at T+1, rd_done at T+1, rd_valid never asserted.
- Write latency: wr_ack is in the same cycle as ram_write. The RAM holds the data from the next edge.
- rd_start and wr_req in the same IDLE cycle: the write is granted that cycle, and the burst starts normally at T+1.

## Test plan
- Reset, then idle: all outputs 0. Assert rst mid-burst: rd_valid and rd_busy drop asynchronously, and no rd_done follows.
- Write-only: wr_req with addr 5 / data 0x2A -> wr_ack, ram_write=1, ram_addr=5, ram_data=0x2A in the same cycle. Then burst base=5, len=1 -> rd_valid with rd_data=0x2A at T+2, rd_done at T+2.
- Burst base=FMO_N_ELEM-2, len=4, no writes -> ram_addr sequence FMO_N_ELEM-2, FMO_N_ELEM-1, 0, 1 at T+1..T+4. Four rd_valid beats at T+2..T+5, rd_done at T+5.
- Contention: burst len=4 with wr_req held continuously -> grants alternate write, read, write, read, … All 4 reads complete, and rd_done occurs 4 cycles later than the uncontended case.
- rd_len=0 -> rd_done at T+1, no ram reads, no rd_valid. rd_start during READ is ignored: burst length unchanged and exactly one rd_done.
- Read-after-write ordering: write 0x11 to addr 3 granted before the read of addr 3 -> returns 0x11. Granted after -> returns the prior value.
